// File: rtl/sample_sink.sv
// sample_sink: requests a sample every RATE_DIV cycles, shifts it MSB-first to a serial DAC, and re-sends the held sample when the source does not answer.
// Latency: a frame starts the cycle after new_sample_ready, or TIMEOUT WAIT cycles after the request; no backpressure, and the source has TIMEOUT cycles to answer.
module sample_sink #(
  parameter int RATE_DIV      = 1024,
  parameter int BIT_DIV       = 8,
  parameter int TIMEOUT       = 64,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        generate_next_sample,
  input  logic        new_sample_ready,
  input  logic [15:0] sample_in,
  output logic        dac_sclk,
  output logic        dac_sync,
  output logic        dac_sdata,
  output logic [15:0] sample_held,
  output logic [15:0] sample_count,
  output logic        timeout_err
);

  localparam int PCW = $clog2(RATE_DIV);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int PHW = $clog2(2 * BIT_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [PCW-1:0]   pc;
  logic [TCW-1:0]   wait_cnt;
  logic [PHW-1:0]   phase;
  logic [3:0]       bit_idx;
  logic [15:0]      shreg;
  logic             tick;
  logic             accept;
  logic             expire;
  logic             bit_end;
  logic             frame_end;

  assign tick      = enable && (pc == PCW'(RATE_DIV - 1));
  assign accept    = (state == S_WAIT) && new_sample_ready;
  assign expire    = (state == S_WAIT) && !new_sample_ready && (wait_cnt == TCW'(TIMEOUT - 1));
  assign bit_end   = (phase == PHW'(2 * BIT_DIV - 1));
  assign frame_end = (state == S_SHIFT) && bit_end && (bit_idx == 4'd15);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
    end else if (!enable || pc == PCW'(RATE_DIV - 1)) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    generate_next_sample = 1'b0;
    dac_sync             = 1'b1;
    dac_sclk             = 1'b0;
    dac_sdata            = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_REQUEST;
      end
      S_REQUEST: begin
        generate_next_sample = 1'b1;
        state_nxt            = S_WAIT;
      end
      S_WAIT: begin
        if (accept || expire) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        dac_sync  = 1'b0;
        dac_sclk  = (phase >= PHW'(BIT_DIV));
        dac_sdata = shreg[15];
        if (frame_end) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (tick) state_nxt = S_REQUEST;
        else if (!enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A timeout re-sends the previously held sample, so the DAC never sees a gap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt     <= '0;
      phase        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      sample_held  <= '0;
      sample_count <= '0;
      timeout_err  <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;

      if (accept) begin
        sample_held  <= sample_in;
        sample_count <= sample_count + 16'd1;
        shreg        <= {sample_in[15] ^ OFFSET_BINARY, sample_in[14:0]};
      end else if (expire) begin
        timeout_err <= 1'b1;
        shreg       <= {sample_held[15] ^ OFFSET_BINARY, sample_held[14:0]};
      end else if (state == S_SHIFT && bit_end) begin
        shreg <= {shreg[14:0], 1'b0};
      end

      if (state != S_SHIFT) begin
        phase   <= '0;
        bit_idx <= '0;
      end else if (bit_end) begin
        phase   <= '0;
        bit_idx <= bit_idx + 4'd1;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule
